// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input logic [1:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op == OP_MULT || op == OP_DIV;
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Shared 2*WIDTH accumulator with one shift-add (multiply) or restoring
// trial-subtract (divide) step per cycle.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   init_lo_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     lhs, res;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    // Divide works on the remainder shifted left by one, so it needs an extra top bit.
    lhs    = is_div_i ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}
                      : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    res    = is_div_i ? lhs - {1'b0, opnd_q} : lhs + {1'b0, opnd_q};

    if (load_i) begin
      acc_d  = {{WIDTH{1'b0}}, init_lo_i};
      opnd_d = opnd_i;
    end else if (step_i) begin
      if (is_div_i) begin
        if (res[WIDTH]) begin
          acc_d = {lhs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
      end else if (acc_q[0]) begin
        acc_d = {res, acc_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Operands are made unsigned at capture; FIX restores the signs.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             hilo_we_i,
  input  logic             hilo_sel_i,
  input  logic [WIDTH-1:0] hilo_wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               dp_load, dp_step;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

  always_comb begin
    sgn_a = op_is_signed(op_i) & rs_data_i[WIDTH-1];
    sgn_b = op_is_signed(op_i) & rt_data_i[WIDTH-1];
    abs_a = sgn_a ? -rs_data_i : rs_data_i;
    abs_b = sgn_b ? -rt_data_i : rt_data_i;
  end

  assign dp_load = (state_q == S_IDLE) && start_i;
  assign dp_step = (state_q == S_CALC);

  mdu_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .is_div_i (is_div_q),
    .init_lo_i(abs_a),
    .opnd_i   (abs_b),
    .acc_o    (acc)
  );

  always_comb begin
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    prod_fix = neg_quo_q ? -acc : acc;
    quo_fix  = neg_quo_q ? -quo : quo;
    // On divide-by-zero the remainder is |A|; re-signing it gives back raw A.
    rem_fix  = neg_rem_q ? -rem : rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          neg_quo_d = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          is_div_d  = op_is_div(op_i);
          div0_d    = op_is_div(op_i) && (rt_data_i == '0);
        end else if (hilo_we_i) begin
          if (hilo_sel_i) begin
            hi_d = hilo_wdata_i;
          end else begin
            lo_d = hilo_wdata_i;
          end
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = rem_fix;
          lo_d = WIDTH'(DIV0_LO);
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        hilo_we = 1'b0;
  logic        hilo_sel = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .op_i        (op),
    .rs_data_i   (rs),
    .rt_data_i   (rt),
    .hilo_we_i   (hilo_we),
    .hilo_sel_i  (hilo_sel),
    .hilo_wdata_i(wdata),
    .hi_o        (hi),
    .lo_o        (lo),
    .busy_o      (busy),
    .done_o      (done)
  );

  // {hi, lo} from the instruction-set definition of each operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output int dcnt, output logic done_end);
    @(negedge clk);
    op = o; rs = a; rt = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcyc = 0;
    dcnt = 0;
    while (busy && bcyc < 100) begin
      bcyc++;
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    done_end = done;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops[8]  = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00};
    logic [31:0] as[8]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'hFFFF_FFFB, 32'h8000_0000};
    logic [31:0] bs[8]   = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0,
                             32'd0, 32'h8000_0000};
    logic [31:0] ehi[8]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'd2,
                             32'd100, 32'hFFFF_FFFB, 32'h4000_0000};
    logic [31:0] elo[8]  = '{32'h1, 32'hFFFF_FFF1, 32'h8000_0000, 32'hFFFF_FFFD, 32'd14,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    int bc, dc;
    logic de;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], bc, dc, de);
      tests++;
      if (bc != 33) begin fails++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bc); end
      tests++;
      if (de !== 1'b1 || dc != 0) begin
        fails++; $display("FAIL dir%0d_done: got end=%b early=%0d want 1/0", i, de, dc);
      end
      tests++;
      if (hi !== ehi[i]) begin fails++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, ehi[i]); end
      tests++;
      if (lo !== elo[i]) begin fails++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, elo[i]); end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int bc, dc;
    logic de;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp = model(o, a, b);
      run_op(o, a, b, bc, dc, de);
      tests++;
      if (bc != 33 || de !== 1'b1) begin
        fails++; $display("FAIL rnd%0d_timing: got busy=%0d done=%b want 33/1", i, bc, de);
      end
      tests++;
      if ({hi, lo} !== exp) begin
        fails++;
        $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h_%h want %h_%h",
                 i, o, a, b, hi, lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int bc = 0;
    int dc = 0;
    logic [31:0] hi_before;
    hi_before = hi;
    @(negedge clk);
    op = 2'b01; rs = 32'd3; rt = 32'd4; start = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (busy) bc++;
      if (done) dc++;
      if (c == 0) start = 1'b0;
      else if (c == 4) begin start = 1'b1; op = 2'b00; rs = 32'd7; rt = 32'd9; end
      else if (c == 5) begin start = 1'b0; hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'hAAAA; end
      else if (c == 6) hilo_we = 1'b0;
      else if (c == 8) begin
        tests++;
        if (hi !== hi_before) begin
          fails++; $display("FAIL busy_hi_hold: got %h want %h", hi, hi_before);
        end
      end
    end
    tests++; if (bc != 33) begin fails++; $display("FAIL restart_busy: got %0d want 33", bc); end
    tests++; if (dc != 1) begin fails++; $display("FAIL restart_done_count: got %0d want 1", dc); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL restart_hi: got %h want 0", hi); end
    tests++; if (lo !== 32'd12) begin fails++; $display("FAIL restart_lo: got %h want c", lo); end
  endtask

  task automatic test_start_wins();
    int bc = 0;
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h5555;
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h9999;
    start = 1'b1; op = 2'b01; rs = 32'd6; rt = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; hilo_we = 1'b0;
    tests++; if (lo !== 32'h5555) begin fails++; $display("FAIL start_wins_lo: got %h want 5555", lo); end
    while (busy && bc < 100) begin bc++; @(posedge clk); #1; end
    tests++;
    if (busy !== 1'b0 || lo !== 32'd42 || hi !== 32'h0) begin
      fails++; $display("FAIL start_wins_result: got busy=%b %h_%h want 0 0_2a", busy, hi, lo);
    end
  endtask

  task automatic test_abort_reset();
    int bc, dc;
    logic de;
    run_op(2'b11, 32'd100, 32'd7, bc, dc, de);
    tests++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      fails++; $display("FAIL abort_prior: got %h_%h want 2_e", hi, lo);
    end
    @(negedge clk);
    op = 2'b11; rs = 32'd500; rt = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL abort_hi: got %h want 0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL abort_lo: got %h want 0", lo); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    bc = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) dc++;
      if (busy) bc++;
    end
    tests++;
    if (dc != 0 || bc != 0) begin
      fails++; $display("FAIL abort_quiet: got done=%0d busy=%0d want 0/0", dc, bc);
    end
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h1234;
    @(posedge clk); #1;
    hilo_we = 1'b0;
    tests++; if (lo !== 32'h1234) begin fails++; $display("FAIL mtlo: got %h want 1234", lo); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mtlo_done: got %b want 0", done); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL mtlo_hi: got %h want 0", hi); end
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'hBEEF;
    @(posedge clk); #1;
    hilo_we = 1'b0;
    tests++;
    if (hi !== 32'hBEEF || lo !== 32'h1234 || done !== 1'b0) begin
      fails++; $display("FAIL mthi: got %h_%h done=%b want beef_1234 0", hi, lo, done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_start_wins();
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that sits directly downstream of the register file read ports.
- Takes the two register read values and produces a 64-bit result in dedicated HI/LO registers.
- The HI/LO registers feed the register-file write-data mux for mfhi/mflo.
- Asserts busy so the control unit stalls the PC while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request, sampled on the rising edge.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  WIDTH  operand A (multiplicand/dividend), from register file read_data1.
- rt_data  input  WIDTH  operand B (multiplier/divisor), from register file read_data2.
- hilo_we  input  1  direct write for mthi/mtlo.
- hilo_sel  input  1  direct-write target: 0 LO, 1 HI.
- hilo_wdata  input  WIDTH  direct-write data (rs_data path).
- hi  output  WIDTH  HI register: product upper half or remainder.
- lo  output  WIDTH  LO register: product lower half or quotient.
- busy  output  1  operation in progress; the control unit stalls on it.
- done  output  1  one-cycle pulse when hi/lo have just been updated by an operation.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - Internal working registers are cleared.
  - Reset mid-operation aborts the operation with no partial hi/lo update.
- States:
  - IDLE: busy=0. If start=1, capture operands and op, then go to CALC. Set busy=1 and counter=0 at the same edge.
  - CALC: one radix-2 iteration per cycle. After WIDTH iterations (counter==WIDTH-1 at the edge), go to FIX.
  - FIX: apply the sign correction, write hi/lo, pulse done=1, return to IDLE, busy=0.
- Latency:
  - start sampled at edge E0; iterations occur at edges E1..E32; FIX at E33.
  - hi/lo are updated, and done=1, busy=0, during the cycle following E33.
  - busy is high for exactly 33 cycles.
- Capture for signed ops (MULT, DIV): store the absolute values of the operands. Record neg_q = sign(A) XOR sign(B) and neg_r = sign(A).
- Capture for unsigned ops: store the operands as-is; neg_q = neg_r = 0.
- Multiply: shift-add over a 2*WIDTH accumulator.
  - FIX negates the full 64-bit product when neg_q=1.
  - hi = product[63:32], lo = product[31:0].
- Divide: restoring division.
  - Each iteration shifts the remainder/quotient pair left by one, trial-subtracts the divisor, and keeps the result if it is non-negative.
  - FIX negates the quotient when neg_q=1 and the remainder when neg_r=1.
  - lo = quotient, hi = remainder.
- Divide by zero (rt_data==0 at capture):
  - Still takes the full 33 cycles; no hang.
  - Result is fixed as hi = rs_data as captured (raw, unsigned view), lo = 0xFFFFFFFF.
  - Sign correction is skipped.
- Signed overflow: 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. This falls out of the abs/negate scheme; no special case is needed.
- start while busy=1 is ignored; the in-flight operation is unaffected.
- hilo_we:
  - Honoured only in IDLE with start=0; updates the selected register at the edge and does not pulse done.
  - If start and hilo_we are both high in IDLE, start wins and the write is dropped.
  - hilo_we while busy is ignored.
- hi/lo hold their values in all other cycles, including during CALC. mfhi/mflo reads during busy return the old values, and the control unit must stall them.
- done is high for exactly one cycle per completed operation and is never asserted by reset or hilo_we.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encodings S_IDLE, S_CALC, S_FIX;
  - constant DIV0_LO = 32'hFFFFFFFF.
- One sub-module, mdu_datapath: the accumulator/remainder registers plus a per-cycle add/subtract step controlled by an is_div input.
- The top level keeps the FSM, counter, sign flags, and HI/LO registers.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 busy cycles, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 (0xFFFFFFFD) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 100 / 0 -> busy still drops after 33 cycles; hi=100, lo=0xFFFFFFFF.
- start re-asserted at cycle 5 of MULTU 3x4 with different operands, then hilo_we hilo_sel=1 wdata=0xAAAA while busy -> result hi=0, lo=12; exactly one done pulse; HI not overwritten.
- rst_n pulled low at cycle 10 of a DIVU after a prior result hi=2, lo=14 -> hi=0, lo=0, busy=0 immediately; no done; mtlo 0x1234 in IDLE afterwards -> lo=0x1234, no done.
